// File: rtl/ps2_receive.sv
// ps2_receive: device-to-host PS/2 receiver.
//   Synchronises and de-glitches the raw PS/2 clock and data pins.
//   Deserialises 11-bit frames (start, 8 data bits LSB-first, odd parity, stop).
//   Good bytes go into a one-entry buffer with a valid/ready handshake.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   ps2_clk_in/data_in     raw asynchronous PS/2 pins
//   inhibit                host owns the bus: abort and suppress reception
//   scan_code_ready        consumer takes the buffered byte
//   scan_code_valid/byte   buffered byte and its valid flag
//   frame_error            1-cycle pulse on start/parity/stop/timeout failure
//   overrun                1-cycle pulse when a good byte is dropped (buffer full)
module ps2_receive #(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic       inhibit,
  input  logic       scan_code_ready,
  output logic       scan_code_valid,
  output logic [7:0] scan_code_byte,
  output logic       frame_error,
  output logic       overrun
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_s, data_s;
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ferr_d, deliver;

  logic          valid_q, valid_d;
  logic [7:0]    byte_q, byte_d;
  logic          ferr_q, ovr_q, ovr_d, load;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // Filtered clock flips on the FILTER_CYCLES-th consecutive disagreeing
  // sample; any agreeing sample restarts the count.
  always_comb begin
    filt_cnt_d = '0;
    filt_clk_d = filt_clk_q;
    if (clk_s != filt_clk_q) begin
      if (filt_cnt_q == FW'(FILTER_CYCLES - 1)) filt_clk_d = clk_s;
      else                                      filt_cnt_d = filt_cnt_q + FW'(1);
    end
  end

  // Falling edge is recognised in the cycle the filter decides to flip.
  assign fall = filt_clk_q & ~filt_clk_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = tmo_q;
    ferr_d    = 1'b0;
    deliver   = 1'b0;
    if (inhibit) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      tmo_d     = '0;
    end else if (state_q != S_IDLE && tmo_q == TW'(TIMEOUT_CYCLES)) begin
      state_d = S_IDLE;
      tmo_d   = '0;
      ferr_d  = 1'b1;
    end else begin
      tmo_d = (state_q == S_IDLE || fall) ? '0 : tmo_q + TW'(1);
      if (fall) begin
        case (state_q)
          S_IDLE: begin
            if (!data_s) begin
              state_d   = S_DATA;
              bit_cnt_d = '0;
            end else begin
              ferr_d = 1'b1;
            end
          end
          S_DATA: begin
            shift_d   = {data_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = S_PARITY;
          end
          S_PARITY: begin
            parity_d = data_s;
            state_d  = S_STOP;
          end
          S_STOP: begin
            state_d = S_IDLE;
            if (data_s && (^shift_q ^ parity_q)) deliver = 1'b1;
            else                                  ferr_d  = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Load when empty or when the current byte is taken in the same cycle.
  assign load    = deliver & (~valid_q | scan_code_ready);
  assign ovr_d   = deliver & valid_q & ~scan_code_ready;
  assign valid_d = load | (valid_q & ~scan_code_ready);
  assign byte_d  = load ? shift_q : byte_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      valid_q     <= 1'b0;
      byte_q      <= '0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      valid_q     <= valid_d;
      byte_q      <= byte_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign scan_code_valid = valid_q;
  assign scan_code_byte  = byte_q;
  assign frame_error     = ferr_q;
  assign overrun         = ovr_q;
endmodule
